// File: rtl/aemb2_dmau.sv
// aemb2_dmau - data memory access unit.
//
// Takes a load/store from EX, runs one STB/ACK data-bus cycle and holds the
// pipeline through dwb_fb until the bus cycle finishes. Load results come back
// lane-aligned and zero-extended on dwb_mx. Bus errors, timeouts and misaligned
// requests are reported on exc_dwb.
//
// Ports
//   gclk, grst        clock, async active-low reset
//   dena              pipeline advance; requests are only taken when high
//   req_ex, wre_ex    request valid, 1 = store
//   siz_ex            00 byte, 01 half, 10/11 word
//   adr_ex, dat_ex    byte address, right-aligned store data
//   dwb_*_o           bus address (word), data, lane selects, strobe, cycle, write
//   dwb_dat_i/ack_i/err_i  bus return path
//   dwb_fb            bus free (state == IDLE)
//   dwb_mx            aligned load result
//   exc_dwb           [1] fault valid, [0] 1 = misalign, 0 = bus error/timeout
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no bus cycle; accepts requests when dena=1
// BUSY  | bus cycle in flight; waits for ack, err or timeout

module aemb2_dmau #(
    parameter int AEMB_DWB = 32,
    parameter int AEMB_DTO = 0
) (
    input  logic                gclk,
    input  logic                grst,
    input  logic                dena,
    input  logic                req_ex,
    input  logic                wre_ex,
    input  logic [1:0]          siz_ex,
    input  logic [AEMB_DWB-1:0] adr_ex,
    input  logic [31:0]         dat_ex,
    output logic [AEMB_DWB-3:0] dwb_adr_o,
    output logic [31:0]         dwb_dat_o,
    output logic [3:0]          dwb_sel_o,
    output logic                dwb_stb_o,
    output logic                dwb_cyc_o,
    output logic                dwb_wre_o,
    input  logic [31:0]         dwb_dat_i,
    input  logic                dwb_ack_i,
    input  logic                dwb_err_i,
    output logic                dwb_fb,
    output logic [31:0]         dwb_mx,
    output logic [1:0]          exc_dwb
);

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    // AEMB_DTO = 0 wraps to 8'hFF here, but the compare is gated off anyway.
    localparam logic [7:0] TO_LAST = 8'(AEMB_DTO - 1);

    state_t      state;
    logic [7:0]  tmo_cnt;
    logic [1:0]  siz_q;
    logic [1:0]  adr_lo_q;

    logic        is_byte;
    logic        is_half;
    logic        misalign;
    logic [3:0]  sel_ex;
    logic [31:0] dat_rep;
    logic [31:0] ld_data;
    logic        tmo;

    assign is_byte  = (siz_ex == 2'b00);
    assign is_half  = (siz_ex == 2'b01);
    assign misalign = (is_half & adr_ex[0]) | (!is_byte & !is_half & (adr_ex[1:0] != 2'b00));

    always_comb begin
        sel_ex  = 4'b1111;
        dat_rep = dat_ex;
        if (is_byte) begin
            sel_ex  = 4'b1000 >> adr_ex[1:0];
            dat_rep = {4{dat_ex[7:0]}};
        end else if (is_half) begin
            sel_ex  = adr_ex[1] ? 4'b0011 : 4'b1100;
            dat_rep = {2{dat_ex[15:0]}};
        end
    end

    // Big-endian lanes: byte address 0 lives in bits 31:24.
    always_comb begin
        ld_data = dwb_dat_i;
        if (siz_q == 2'b00) begin
            case (adr_lo_q)
                2'b00:   ld_data = {24'd0, dwb_dat_i[31:24]};
                2'b01:   ld_data = {24'd0, dwb_dat_i[23:16]};
                2'b10:   ld_data = {24'd0, dwb_dat_i[15:8]};
                default: ld_data = {24'd0, dwb_dat_i[7:0]};
            endcase
        end else if (siz_q == 2'b01) begin
            ld_data = adr_lo_q[1] ? {16'd0, dwb_dat_i[15:0]} : {16'd0, dwb_dat_i[31:16]};
        end
    end

    assign tmo       = (AEMB_DTO != 0) && (tmo_cnt == TO_LAST);
    assign dwb_fb    = (state == IDLE);
    assign dwb_cyc_o = dwb_stb_o;

    always_ff @(posedge gclk or negedge grst) begin
        if (!grst) begin
            state     <= IDLE;
            tmo_cnt   <= 8'd0;
            siz_q     <= 2'b00;
            adr_lo_q  <= 2'b00;
            dwb_adr_o <= '0;
            dwb_dat_o <= 32'd0;
            dwb_sel_o <= 4'd0;
            dwb_stb_o <= 1'b0;
            dwb_wre_o <= 1'b0;
            dwb_mx    <= 32'd0;
            exc_dwb   <= 2'b00;
        end else begin
            // A fault raised below overrides this clear.
            if (dena) exc_dwb <= 2'b00;

            case (state)
                IDLE: begin
                    if (dena && req_ex) begin
                        if (misalign) begin
                            exc_dwb <= 2'b11;
                        end else begin
                            state     <= BUSY;
                            tmo_cnt   <= 8'd0;
                            siz_q     <= siz_ex;
                            adr_lo_q  <= adr_ex[1:0];
                            dwb_adr_o <= adr_ex[AEMB_DWB-1:2];
                            dwb_dat_o <= dat_rep;
                            dwb_sel_o <= sel_ex;
                            dwb_wre_o <= wre_ex;
                            dwb_stb_o <= 1'b1;
                        end
                    end
                end
                BUSY: begin
                    if (dwb_err_i || tmo) begin
                        state     <= IDLE;
                        dwb_stb_o <= 1'b0;
                        exc_dwb   <= 2'b10;
                    end else if (dwb_ack_i) begin
                        state     <= IDLE;
                        dwb_stb_o <= 1'b0;
                        if (!dwb_wre_o) dwb_mx <= ld_data;
                    end else if (tmo_cnt != 8'hFF) begin
                        tmo_cnt <= tmo_cnt + 8'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_aemb2_dmau.sv
// Directed bench for aemb2_dmau. u_dut has no watchdog; u_tmo (AEMB_DTO=4)
// never sees an ack and is used for the timeout case. dena is gated by
// dwb_fb the way the surrounding system does it.
module tb_aemb2_dmau;

    logic        gclk = 1'b0;
    logic        grst = 1'b1;
    logic        dena_raw = 1'b1;
    logic        req0 = 1'b0, req1 = 1'b0;
    logic        wre_ex = 1'b0;
    logic [1:0]  siz_ex = 2'b10;
    logic [31:0] adr_ex = 32'd0;
    logic [31:0] dat_ex = 32'd0;
    logic [31:0] dwb_dat_i = 32'd0;
    logic        dwb_ack_i = 1'b0, dwb_err_i = 1'b0;

    logic [29:0] adr_o0, adr_o1;
    logic [31:0] dat_o0, dat_o1, mx0, mx1;
    logic [3:0]  sel0, sel1;
    logic        stb0, stb1, cyc0, cyc1, wre0, wre1, fb0, fb1;
    logic [1:0]  exc0, exc1;
    logic        dena0, dena1;

    int n_chk = 0;
    int n_fail = 0;

    assign dena0 = dena_raw & fb0;
    assign dena1 = dena_raw & fb1;

    always #5 gclk = ~gclk;

    aemb2_dmau #(.AEMB_DWB(32), .AEMB_DTO(0)) u_dut (
        .gclk(gclk), .grst(grst), .dena(dena0), .req_ex(req0), .wre_ex(wre_ex),
        .siz_ex(siz_ex), .adr_ex(adr_ex), .dat_ex(dat_ex),
        .dwb_adr_o(adr_o0), .dwb_dat_o(dat_o0), .dwb_sel_o(sel0), .dwb_stb_o(stb0),
        .dwb_cyc_o(cyc0), .dwb_wre_o(wre0), .dwb_dat_i(dwb_dat_i), .dwb_ack_i(dwb_ack_i),
        .dwb_err_i(dwb_err_i), .dwb_fb(fb0), .dwb_mx(mx0), .exc_dwb(exc0)
    );

    aemb2_dmau #(.AEMB_DWB(32), .AEMB_DTO(4)) u_tmo (
        .gclk(gclk), .grst(grst), .dena(dena1), .req_ex(req1), .wre_ex(wre_ex),
        .siz_ex(siz_ex), .adr_ex(adr_ex), .dat_ex(dat_ex),
        .dwb_adr_o(adr_o1), .dwb_dat_o(dat_o1), .dwb_sel_o(sel1), .dwb_stb_o(stb1),
        .dwb_cyc_o(cyc1), .dwb_wre_o(wre1), .dwb_dat_i(dwb_dat_i), .dwb_ack_i(1'b0),
        .dwb_err_i(1'b0), .dwb_fb(fb1), .dwb_mx(mx1), .exc_dwb(exc1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One request on u_dut. Bus fields are captured in the first BUSY cycle;
    // the slave answers after 'waits' wait cycles. fb_low counts cycles with dwb_fb=0.
    logic [3:0]  c_sel;
    logic [31:0] c_dat;
    logic [29:0] c_adr;
    logic        c_stb, c_cyc, c_wre;
    int          fb_low;

    task automatic bus_op(input logic wre, input logic [1:0] siz, input logic [31:0] adr,
                          input logic [31:0] dat, input int waits, input logic [31:0] rdata,
                          input logic ack_v, input logic err_v);
        @(negedge gclk);
        wre_ex = wre; siz_ex = siz; adr_ex = adr; dat_ex = dat; req0 = 1'b1;
        @(negedge gclk);
        req0 = 1'b0;
        c_sel = sel0; c_dat = dat_o0; c_adr = adr_o0; c_stb = stb0; c_cyc = cyc0; c_wre = wre0;
        fb_low = 0;
        for (int i = 0; i < waits; i++) begin
            if (!fb0) fb_low++;
            @(negedge gclk);
        end
        if (!fb0) fb_low++;
        dwb_ack_i = ack_v; dwb_err_i = err_v; dwb_dat_i = rdata;
        @(negedge gclk);
        dwb_ack_i = 1'b0; dwb_err_i = 1'b0;
    endtask

    initial begin
        #1 grst = 1'b0;
        repeat (2) @(negedge gclk);
        chk("rst_fb", 32'(fb0), 32'd1);
        chk("rst_stb", 32'(stb0), 32'd0);
        chk("rst_cyc", 32'(cyc0), 32'd0);
        chk("rst_sel", 32'(sel0), 32'd0);
        chk("rst_wre", 32'(wre0), 32'd0);
        chk("rst_adr", 32'(adr_o0), 32'd0);
        chk("rst_dat", dat_o0, 32'd0);
        chk("rst_mx", mx0, 32'd0);
        chk("rst_exc", 32'(exc0), 32'd0);
        grst = 1'b1;

        // Word load, zero-wait ack
        bus_op(1'b0, 2'b10, 32'h100, 32'd0, 0, 32'hDEADBEEF, 1'b1, 1'b0);
        chk("wld_stb", 32'(c_stb), 32'd1);
        chk("wld_cyc", 32'(c_cyc), 32'd1);
        chk("wld_sel", 32'(c_sel), 32'hF);
        chk("wld_adr", 32'(c_adr), 32'h40);
        chk("wld_wre", 32'(c_wre), 32'd0);
        chk("wld_fblow", 32'(fb_low), 32'd1);
        chk("wld_mx", mx0, 32'hDEADBEEF);
        chk("wld_stb_after", 32'(stb0), 32'd0);
        chk("wld_exc", 32'(exc0), 32'd0);

        // Byte store to lane 3
        bus_op(1'b1, 2'b00, 32'h103, 32'h000000A5, 0, 32'h55555555, 1'b1, 1'b0);
        chk("bst_sel", 32'(c_sel), 32'h1);
        chk("bst_dat", c_dat, 32'hA5A5A5A5);
        chk("bst_wre", 32'(c_wre), 32'd1);
        chk("bst_mx", mx0, 32'hDEADBEEF);

        // Half load, three wait states
        bus_op(1'b0, 2'b01, 32'h102, 32'd0, 3, 32'h1234ABCD, 1'b1, 1'b0);
        chk("hld_sel", 32'(c_sel), 32'h3);
        chk("hld_fblow", 32'(fb_low), 32'd4);
        chk("hld_mx", mx0, 32'h0000ABCD);

        // Half load upper half, byte load lane 1
        bus_op(1'b0, 2'b01, 32'h200, 32'd0, 0, 32'h1234ABCD, 1'b1, 1'b0);
        chk("hld0_sel", 32'(c_sel), 32'hC);
        chk("hld0_mx", mx0, 32'h00001234);
        bus_op(1'b0, 2'b00, 32'h101, 32'd0, 1, 32'h11223344, 1'b1, 1'b0);
        chk("bld_sel", 32'(c_sel), 32'h4);
        chk("bld_fblow", 32'(fb_low), 32'd2);
        chk("bld_mx", mx0, 32'h00000022);

        // Half store
        bus_op(1'b1, 2'b01, 32'h106, 32'h0000BEEF, 0, 32'd0, 1'b1, 1'b0);
        chk("hst_sel", 32'(c_sel), 32'h3);
        chk("hst_dat", c_dat, 32'hBEEFBEEF);
        chk("hst_adr", 32'(c_adr), 32'h41);
        chk("hst_mx", mx0, 32'h00000022);

        // Misaligned word load: no bus cycle, fault for one dena edge
        @(negedge gclk);
        wre_ex = 1'b0; siz_ex = 2'b10; adr_ex = 32'h101; req0 = 1'b1;
        @(negedge gclk);
        req0 = 1'b0;
        chk("mis_stb", 32'(stb0), 32'd0);
        chk("mis_fb", 32'(fb0), 32'd1);
        chk("mis_exc", 32'(exc0), 32'h3);
        @(negedge gclk);
        chk("mis_exc_clr", 32'(exc0), 32'd0);

        // Misaligned half load
        siz_ex = 2'b01; adr_ex = 32'h103; req0 = 1'b1;
        @(negedge gclk);
        req0 = 1'b0;
        chk("mish_exc", 32'(exc0), 32'h3);
        chk("mish_stb", 32'(stb0), 32'd0);

        // Request without dena is ignored
        dena_raw = 1'b0; siz_ex = 2'b10; adr_ex = 32'h300; req0 = 1'b1;
        @(negedge gclk);
        req0 = 1'b0;
        chk("nodena_stb", 32'(stb0), 32'd0);
        chk("nodena_exc", 32'(exc0), 32'h3);
        dena_raw = 1'b1;
        @(negedge gclk);
        chk("nodena_exc_clr", 32'(exc0), 32'd0);

        // ack and err together: err wins, mx unchanged
        bus_op(1'b0, 2'b10, 32'h200, 32'd0, 0, 32'hFFFFFFFF, 1'b1, 1'b1);
        chk("err_exc", 32'(exc0), 32'h2);
        chk("err_mx", mx0, 32'h00000022);
        chk("err_fb", 32'(fb0), 32'd1);
        @(negedge gclk);
        chk("err_exc_clr", 32'(exc0), 32'd0);

        // Watchdog on u_tmo: four BUSY cycles then abort
        begin
            int lowc;
            lowc = 0;
            siz_ex = 2'b10; adr_ex = 32'h400; wre_ex = 1'b0; req1 = 1'b1;
            @(negedge gclk);
            req1 = 1'b0;
            chk("tmo_stb", 32'(stb1), 32'd1);
            for (int i = 0; i < 20 && !fb1; i++) begin
                lowc++;
                @(negedge gclk);
            end
            chk("tmo_busy_cycles", 32'(lowc), 32'd4);
            chk("tmo_exc", 32'(exc1), 32'h2);
            chk("tmo_stb_after", 32'(stb1), 32'd0);
        end

        // Reset during BUSY
        @(negedge gclk);
        siz_ex = 2'b10; adr_ex = 32'h300; req0 = 1'b1;
        @(negedge gclk);
        req0 = 1'b0;
        chk("rb_stb_busy", 32'(stb0), 32'd1);
        #2 grst = 1'b0;
        #1;
        chk("rb_stb", 32'(stb0), 32'd0);
        chk("rb_cyc", 32'(cyc0), 32'd0);
        chk("rb_fb", 32'(fb0), 32'd1);
        @(negedge gclk);
        grst = 1'b1;
        bus_op(1'b0, 2'b10, 32'h104, 32'd0, 1, 32'hCAFEF00D, 1'b1, 1'b0);
        chk("rb_adr", 32'(c_adr), 32'h41);
        chk("rb_fblow", 32'(fb_low), 32'd2);
        chk("rb_mx", mx0, 32'hCAFEF00D);
        chk("rb_exc", 32'(exc0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
